rs_issue_queue: RTL
===================

Name: rs_issue_queue

Overview:
- Parametrised single-FU-class reservation station; successor to the fixed four-FIFO station block.
- Out-of-order issue: the oldest entry whose sources are ready issues, not just the head.
- Multi-port CDB tag wakeup, with bypass at dispatch.
- Sits between dispatch and one functional unit; one instance per FU class.

Parameters:
- DEPTH, 8, number of entries (power of two not required, >=2).
- TAG_WIDTH, 6, physical register tag width.
- PAYLOAD_WIDTH, 64, opaque instruction payload bits carried to the FU.
- CDB_PORTS, 2, number of CDB broadcast ports checked per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries.
- disp_valid  in  1  dispatch offers an instruction.
- disp_ready  out  1  station can accept (count < DEPTH).
- disp_src1_tag  in  TAG_WIDTH  source 1 physical tag.
- disp_src1_rdy  in  1  source 1 already available.
- disp_src2_tag  in  TAG_WIDTH  source 2 physical tag.
- disp_src2_rdy  in  1  source 2 already available (1 if unused).
- disp_payload  in  PAYLOAD_WIDTH  instruction payload.
- cdb_valid  in  CDB_PORTS  per-port broadcast valid.
- cdb_tag  in  CDB_PORTS*TAG_WIDTH  per-port tag; port k occupies bits [k*TAG_WIDTH +: TAG_WIDTH].
- issue_valid  out  1  a ready entry is presented.
- issue_ready  in  1  FU accepts this cycle.
- issue_payload  out  PAYLOAD_WIDTH  payload of the selected entry.
- issue_src1_tag  out  TAG_WIDTH  tag of the selected entry's source 1.
- issue_src2_tag  out  TAG_WIDTH  tag of the selected entry's source 2.
- count  out  $clog2(DEPTH+1)  occupied entries.
- empty  out  1  count==0.

Behaviour:
- Reset (rst low, async): all entry valid bits, ready bits and age matrix are cleared. Outputs: issue_valid=0, issue_payload/tags=0, count=0, empty=1, disp_ready=1. Reset asserted mid-operation discards all contents immediately.
- Entry state: valid, src1_tag, src1_rdy, src2_tag, src2_rdy, payload.
- Age matrix: older[i][j]=1 means entry j is older than entry i.
- Dispatch:
  - Accepted at the edge when disp_valid && disp_ready && !flush.
  - Writes the lowest-index free entry.
  - Sets older[new][j]=valid[j] for all j, and clears older[j][new].
  - disp_ready = (count<DEPTH). It does not count a same-cycle issue, so a full queue rejects dispatch even while issuing.
- Dispatch bypass: if any cdb_valid[k] with cdb_tag[k]==disp_srcN_tag in the accept cycle, the stored srcN_rdy is 1.
- Wakeup: each cycle, every valid entry with srcN_rdy=0 whose srcN_tag matches any valid CDB port sets srcN_rdy at the edge. Multiple ports matching are harmless. Tags of already-ready sources are ignored.
- Select (combinational from registered state only):
  - An entry is eligible iff valid && src1_rdy && src2_rdy.
  - Selected = the eligible i with no eligible j where older[i][j].
  - issue_valid = any eligible && !flush.
  - Payload/tags are zero when issue_valid=0.
- Latency:
  - Dispatch with both sources ready: issuable the cycle after the accept edge.
  - CDB wakeup at cycle t: issuable at t+1.
  - No same-cycle dispatch-to-issue.
- Issue handshake: on issue_valid && issue_ready, the selected entry is invalidated at the edge. Outputs must hold stable while issue_valid=1 && issue_ready=0, unless a newer-eligible older entry wakes; oldest-first always wins.
- Simultaneous dispatch + issue: both occur; count unchanged. The freed slot is reusable from the next cycle.
- Flush: synchronous. All valid bits are cleared at the edge, flush overrides dispatch and issue, issue_valid=0 during the flush cycle, and count=0 next cycle.
- count updates by +accept −fire; it never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then dispatch 8 entries, all sources ready, issue_ready=1 -> issue order equals dispatch order; first issue_valid one cycle after first accept; count returns to 0, empty=1.
- DEPTH=8: fill with src1 tags 10..17 not ready, then hold disp_valid -> disp_ready=0, no overwrite. Then cdb port1 tag 13 -> the entry with tag 13 issues one cycle later ahead of older entries; count=7.
- Entries A (older, tag 5 pending) and B (ready) -> B issues. Then cdb tag 5 -> A issues next cycle.
- Dispatch with src2_tag=9 while cdb_valid[0]=1, cdb_tag[0]=9 -> entry stored ready; issue_valid the next cycle.
- issue_ready=0 for 3 cycles with 2 ready entries -> payload stable, oldest presented. Then issue_ready=1 -> consecutive issues.
- 4 entries valid, flush with disp_valid=1 -> next cycle count=0, dispatch dropped. Also assert rst low mid-burst -> outputs at reset values immediately.

Source files
------------

// File: rtl/rs_issue_queue_if.sv
// Dispatch / CDB / issue bundle for one reservation station instance.
// The master drives dispatch, broadcast, flush and FU-ready; the slave is the station.
interface rs_issue_queue_if #(
  parameter int DEPTH         = 8,
  parameter int TAG_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int CDB_PORTS     = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                           flush;
  logic                           disp_valid;
  logic                           disp_ready;
  logic [TAG_WIDTH-1:0]           disp_src1_tag;
  logic                           disp_src1_rdy;
  logic [TAG_WIDTH-1:0]           disp_src2_tag;
  logic                           disp_src2_rdy;
  logic [PAYLOAD_WIDTH-1:0]       disp_payload;
  logic [CDB_PORTS-1:0]           cdb_valid;
  logic [CDB_PORTS*TAG_WIDTH-1:0] cdb_tag;
  logic                           issue_valid;
  logic                           issue_ready;
  logic [PAYLOAD_WIDTH-1:0]       issue_payload;
  logic [TAG_WIDTH-1:0]           issue_src1_tag;
  logic [TAG_WIDTH-1:0]           issue_src2_tag;
  logic [CW-1:0]                  count;
  logic                           empty;

  modport master (
    output flush, disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag,
           disp_src2_rdy, disp_payload, cdb_valid, cdb_tag, issue_ready,
    input  disp_ready, issue_valid, issue_payload, issue_src1_tag,
           issue_src2_tag, count, empty
  );

  modport slave (
    input  flush, disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag,
           disp_src2_rdy, disp_payload, cdb_valid, cdb_tag, issue_ready,
    output disp_ready, issue_valid, issue_payload, issue_src1_tag,
           issue_src2_tag, count, empty
  );
endinterface

// File: rtl/rs_issue_queue.sv
// Out-of-order reservation station: age-matrix oldest-ready select, multi-port
// CDB wakeup with dispatch bypass, synchronous flush.
module rs_issue_queue #(
  parameter int DEPTH         = 8,
  parameter int TAG_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int CDB_PORTS     = 2
) (
  input logic              clk,
  input logic              rst,
  rs_issue_queue_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [TAG_WIDTH-1:0] tag_t;

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         s1_rdy_q, s1_rdy_d;
  logic [DEPTH-1:0]         s2_rdy_q, s2_rdy_d;
  tag_t                     s1_tag_q [DEPTH];
  tag_t                     s1_tag_d [DEPTH];
  tag_t                     s2_tag_q [DEPTH];
  tag_t                     s2_tag_d [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload_d [DEPTH];
  logic [DEPTH-1:0]         older_q [DEPTH];
  logic [DEPTH-1:0]         older_d [DEPTH];
  logic [CW-1:0]            count_q, count_d;

  logic [DEPTH-1:0] elig;
  logic [IW-1:0]    sel_idx, free_idx;
  logic             issue_vld, accept, fire;

  function automatic logic cdb_hit(input tag_t tag,
                                   input logic [CDB_PORTS-1:0] vld,
                                   input logic [CDB_PORTS*TAG_WIDTH-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_PORTS; k++)
      if (vld[k] && (tags[k*TAG_WIDTH +: TAG_WIDTH] == tag)) hit = 1'b1;
    return hit;
  endfunction

  // The age matrix is a strict order over valid entries, so at most one eligible
  // entry has no older eligible peer.
  always_comb begin
    elig     = valid_q & s1_rdy_q & s2_rdy_q;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (elig[i] && ((older_q[i] & elig) == '0)) sel_idx = IW'(i);
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IW'(i);
  end

  assign issue_vld = (|elig) && !bus.flush;
  assign fire      = issue_vld && bus.issue_ready;
  assign accept    = bus.disp_valid && bus.disp_ready && !bus.flush;

  assign bus.disp_ready     = (count_q < CW'(DEPTH));
  assign bus.issue_valid    = issue_vld;
  assign bus.issue_payload  = issue_vld ? payload_q[sel_idx] : '0;
  assign bus.issue_src1_tag = issue_vld ? s1_tag_q[sel_idx]  : '0;
  assign bus.issue_src2_tag = issue_vld ? s2_tag_q[sel_idx]  : '0;
  assign bus.count          = count_q;
  assign bus.empty          = (count_q == '0);

  always_comb begin
    valid_d   = valid_q;
    s1_rdy_d  = s1_rdy_q;
    s2_rdy_d  = s2_rdy_q;
    s1_tag_d  = s1_tag_q;
    s2_tag_d  = s2_tag_q;
    payload_d = payload_q;
    older_d   = older_q;
    count_d   = count_q;
    if (bus.flush) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !s1_rdy_q[i] && cdb_hit(s1_tag_q[i], bus.cdb_valid, bus.cdb_tag))
          s1_rdy_d[i] = 1'b1;
        if (valid_q[i] && !s2_rdy_q[i] && cdb_hit(s2_tag_q[i], bus.cdb_valid, bus.cdb_tag))
          s2_rdy_d[i] = 1'b1;
      end
      if (fire) valid_d[sel_idx] = 1'b0;
      if (accept) begin
        valid_d[free_idx]   = 1'b1;
        s1_tag_d[free_idx]  = bus.disp_src1_tag;
        s2_tag_d[free_idx]  = bus.disp_src2_tag;
        s1_rdy_d[free_idx]  = bus.disp_src1_rdy ||
                              cdb_hit(bus.disp_src1_tag, bus.cdb_valid, bus.cdb_tag);
        s2_rdy_d[free_idx]  = bus.disp_src2_rdy ||
                              cdb_hit(bus.disp_src2_tag, bus.cdb_valid, bus.cdb_tag);
        payload_d[free_idx] = bus.disp_payload;
        for (int j = 0; j < DEPTH; j++) older_d[j][free_idx] = 1'b0;
        older_d[free_idx] = valid_q;
      end
      count_d = count_q + CW'(accept) - CW'(fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      older_q  <= '{default: '0};
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
      older_q  <= older_d;
      count_q  <= count_d;
    end
  end

  // Tags and payload are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    s1_tag_q  <= s1_tag_d;
    s2_tag_q  <= s2_tag_d;
    payload_q <= payload_d;
  end
endmodule
